// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, ARM-style branch redirect and kill of in-flight fetches.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [23:0] branch_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    output logic        dbg_state
);

    // Handshake: a fetch transfer completes on a rising edge where imem_req && imem_valid;
    // imem_addr is held constant from the cycle imem_req rises until that completion.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_KILL  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_kill_addr;
    logic        r_req_en;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;

    logic        w_hold;
    logic        w_done;
    logic        w_redirect;
    logic [31:0] w_offset;
    logic [31:0] w_target;

    assign w_hold     = stall && r_valid;
    assign w_done     = imem_req && imem_valid;
    assign w_redirect = branch_taken && r_valid && (r_state == ST_FETCH);
    assign w_offset   = {{6{branch_offset[23]}}, branch_offset, 2'b00};
    assign w_target   = r_pc_out + 32'd8 + w_offset;

    // KILL keeps presenting the abandoned address until memory finishes with it.
    assign imem_req    = (r_state == ST_KILL) ? 1'b1 : (r_req_en && !w_hold);
    assign imem_addr   = (r_state == ST_KILL) ? r_kill_addr : r_pc;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_valid;
    assign dbg_state   = (r_state == ST_KILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_VECTOR;
            r_kill_addr <= RESET_VECTOR;
            r_req_en    <= 1'b0;
            r_instr     <= NOP_INSTR;
            r_pc_out    <= RESET_VECTOR;
            r_valid     <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            case (r_state)
                ST_FETCH: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (imem_req && !w_done) begin
                            r_state     <= ST_KILL;
                            r_kill_addr <= r_pc;
                        end
                    end else if (w_done) begin
                        r_instr  <= imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_pc     <= r_pc + 32'd4;
                    end else if (!stall) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                    end
                end
                ST_KILL: begin
                    // The stale word is dropped; a one-cycle request gap separates it from the target fetch.
                    if (w_done) begin
                        r_state  <= ST_FETCH;
                        r_req_en <= 1'b0;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_flushed <= 32'd0;
        end else begin
            if (w_done && !w_redirect && (r_state == ST_FETCH)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_redirect) begin
                r_perf_flushed <= r_perf_flushed + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule
